// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_op_t      : one-hot-free encoding of the operation chosen each cycle
//                  by the priority decoder inside pc_seq.
//   PC_D         : default program-counter width in bits.
//   PC_OFFW      : default signed branch-offset width in bits.
//   PC_RAS_S     : default return-address-stack depth in entries.
//   ras_depth_w  : width needed to count 0..s stack entries inclusive.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_RET,
    PC_CALL,
    PC_ABS,
    PC_REL,
    PC_INC
  } pc_op_t;

  localparam int PC_D     = 10;
  localparam int PC_OFFW  = 8;
  localparam int PC_RAS_S = 4;

  function automatic int ras_depth_w(input int s);
    return $clog2(s + 1);
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Command/status bundle between the control unit and the program-counter
// sequencer.
//   master : control unit; drives stall, ret/call/jump enables, target,
//            offset and clr_err; observes prog_ctr, stack_depth and the
//            sticky RAS error flags.
//   slave  : pc_seq; the reverse directions.
// Optional: with PC_HALT_EN defined the bundle also carries halt_req
// (master -> slave) and halted (slave -> master).
interface pc_seq_if #(
  parameter int D    = 10,
  parameter int OFFW = 8,
  parameter int S    = 4
);

  localparam int DW = $clog2(S + 1);

  logic          stall;
  logic          absjump_en;
  logic          reljump_en;
  logic          call_en;
  logic          ret_en;
  logic [D-1:0]  target;
  logic [OFFW-1:0] offset;
  logic          clr_err;
  logic [D-1:0]  prog_ctr;
  logic [DW-1:0] stack_depth;
  logic          ras_ovf;
  logic          ras_unf;
`ifdef PC_HALT_EN
  logic          halt_req;
  logic          halted;
`endif

  modport master (
    output stall,
    output absjump_en,
    output reljump_en,
    output call_en,
    output ret_en,
    output target,
    output offset,
    output clr_err,
`ifdef PC_HALT_EN
    output halt_req,
    input  halted,
`endif
    input  prog_ctr,
    input  stack_depth,
    input  ras_ovf,
    input  ras_unf
  );

  modport slave (
    input  stall,
    input  absjump_en,
    input  reljump_en,
    input  call_en,
    input  ret_en,
    input  target,
    input  offset,
    input  clr_err,
`ifdef PC_HALT_EN
    input  halt_req,
    output halted,
`endif
    output prog_ctr,
    output stack_depth,
    output ras_ovf,
    output ras_unf
  );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of S entries, W bits each.
//   clk, reset  : clock, asynchronous active-low reset (clears depth only;
//                 entry contents are left undefined)
//   push        : write push_data at index depth, depth+1 (ignored if full)
//   pop         : depth-1 (ignored if empty)
//   push_data   : value to push
//   top         : entry at depth-1, read combinationally ('0 when empty)
//   full, empty : depth == S, depth == 0
//   depth       : number of valid entries
// Callers never assert push and pop together; if they did, push wins.
module pc_ras #(
  parameter int W  = 10,
  parameter int S  = 4,
  parameter int DW = $clog2(S + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);

  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;
  logic          push_ok;
  logic          pop_ok;
  logic [W-1:0]  ent_q [S];

  assign full    = (depth_q == DW'(S));
  assign empty   = (depth_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign depth   = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (push_ok) begin
      depth_d = depth_q + DW'(1);
    end else if (pop_ok) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // The write pointer is the current depth, so entry gi is written only when
  // exactly gi entries are valid. A push on a full stack touches nothing.
  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : g_ent
      always_ff @(posedge clk) begin
        if (push_ok && (depth_q == DW'(gi))) begin
          ent_q[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Select-by-compare instead of indexing with depth-1 keeps the read free
  // of an out-of-range index when the stack is empty.
  always_comb begin
    top = '0;
    for (int i = 0; i < S; i++) begin
      if (depth_q == DW'(i + 1)) begin
        top = ent_q[i];
      end
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer for the fetch stage: increment, absolute jump,
// signed relative branch, call and return through an internal RAS.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-low reset
//   bus   : pc_seq_if.slave; commands stall, ret_en, call_en, absjump_en,
//           reljump_en, target, offset, clr_err; status prog_ctr,
//           stack_depth, ras_ovf, ras_unf (sticky)
// Per-cycle priority: stall > ret > call > absjump > reljump > increment.
// Optional build macro PC_HALT_EN: adds halt_req/halted. A non-stalled
// halt_req latches halted, which freezes PC and RAS and ignores every
// command until reset.
module pc_seq
  import pc_pkg::*;
#(
  parameter int D    = PC_D,
  parameter int OFFW = PC_OFFW,
  parameter int S    = PC_RAS_S
) (
  input logic     clk,
  input logic     reset,
  pc_seq_if.slave bus
);

  localparam int DW = ras_depth_w(S);

  pc_op_t        op;
  logic [D-1:0]  pc_q;
  logic [D-1:0]  pc_d;
  logic [D-1:0]  pc_inc;
  logic [D-1:0]  off_ext;
  logic          ovf_q;
  logic          ovf_d;
  logic          unf_q;
  logic          unf_d;
  logic          ovf_set;
  logic          unf_set;
  logic          clr_eff;
  logic          halt_block;
  logic          ras_push;
  logic          ras_pop;
  logic          ras_full;
  logic          ras_empty;
  logic [D-1:0]  ras_top;
  logic [DW-1:0] ras_depth;

`ifdef PC_HALT_EN
  logic halted_q;
  logic halted_d;

  // Blocks commands both while halted and on the edge that enters halt.
  assign halt_block = halted_q | (~bus.stall & bus.halt_req);
  assign halted_d   = halt_block;
  assign bus.halted = halted_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign halt_block = 1'b0;
`endif

  assign pc_inc  = pc_q + D'(1);
  // Sign-extend through a signed cast so OFFW == D also works.
  assign off_ext = D'($signed(bus.offset));
  assign clr_eff = bus.clr_err & ~halt_block;

  // Priority decoder.
  always_comb begin
    op = PC_INC;
    if (bus.stall || halt_block) begin
      op = PC_HOLD;
    end else if (bus.ret_en) begin
      op = PC_RET;
    end else if (bus.call_en) begin
      op = PC_CALL;
    end else if (bus.absjump_en) begin
      op = PC_ABS;
    end else if (bus.reljump_en) begin
      op = PC_REL;
    end
  end

  // Next PC, RAS control and error-set pulses.
  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    unique case (op)
      PC_HOLD: pc_d = pc_q;
      PC_RET: begin
        if (ras_empty) begin
          unf_set = 1'b1;
          pc_d    = pc_inc;
        end else begin
          ras_pop = 1'b1;
          pc_d    = ras_top;
        end
      end
      PC_CALL: begin
        // The jump is taken even when the push has to be dropped.
        if (ras_full) begin
          ovf_set = 1'b1;
        end else begin
          ras_push = 1'b1;
        end
        pc_d = bus.target;
      end
      PC_ABS:  pc_d = bus.target;
      PC_REL:  pc_d = pc_q + off_ext;
      PC_INC:  pc_d = pc_inc;
      default: pc_d = pc_q;
    endcase
  end

  // A set in the same cycle as clr_err wins.
  always_comb begin
    ovf_d = (ovf_q & ~clr_eff) | ovf_set;
    unf_d = (unf_q & ~clr_eff) | unf_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc_ras #(
    .W  (D),
    .S  (S),
    .DW (DW)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .depth     (ras_depth)
  );

  assign bus.prog_ctr    = pc_q;
  assign bus.stack_depth = ras_depth;
  assign bus.ras_ovf     = ovf_q;
  assign bus.ras_unf     = unf_q;

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Parametrised next-generation program counter for the core fetch stage. It supports sequential increment, absolute jump, signed relative branch, call and return. Call and return use an internal return-address stack (RAS) of configurable depth. A stall input freezes the PC. Sticky error flags report stack overflow and underflow to the control unit.

Parameters:
D, 10, program-counter / address width in bits
OFFW, 8, width of signed relative-branch offset (OFFW <= D)
S, 4, return-address-stack depth in entries (S >= 1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
stall  in  1  hold all state this cycle
absjump_en  in  1  absolute jump to target
reljump_en  in  1  relative branch by offset
call_en  in  1  push return address, jump to target
ret_en  in  1  pop return address into PC
target  in  D  absolute / call destination
offset  in  OFFW  two's-complement branch offset, relative to current PC
clr_err  in  1  clear sticky error flags
prog_ctr  out  D  current program counter
stack_depth  out  $clog2(S+1)  number of valid RAS entries
ras_ovf  out  1  sticky: call issued with RAS full
ras_unf  out  1  sticky: return issued with RAS empty

Behaviour:
- Reset (reset=0, asynchronous) forces prog_ctr=0, stack_depth=0, ras_ovf=0 and ras_unf=0. RAS contents are don't-care. Reset is released synchronously by the integrator; the first update is on the first rising edge with reset=1.
- One-cycle latency: prog_ctr shows the new value on the edge after the command is sampled. Commands are level-sampled every non-stalled cycle; there is no handshake.
- Priority per cycle, highest first: stall > ret_en > call_en > absjump_en > reljump_en > increment. Lower-priority enables are ignored when a higher one is active.
- stall=1: prog_ctr, RAS and stack_depth hold. Error flags hold, except that clr_err still acts.
- ret_en, RAS non-empty: prog_ctr <= top entry; stack_depth decrements.
- ret_en, RAS empty: ras_unf <= 1; prog_ctr <= prog_ctr+1; stack_depth stays 0.
- call_en, RAS not full: push prog_ctr+1 (mod 2^D); prog_ctr <= target; stack_depth increments.
- call_en, RAS full (stack_depth==S): ras_ovf <= 1; the push is dropped and existing entries are untouched; the jump to target is still taken.
- absjump_en: prog_ctr <= target.
- reljump_en: prog_ctr <= prog_ctr + sign_extend(offset), modulo 2^D. Wrap is silent in both directions.
- Otherwise prog_ctr <= prog_ctr + 1, wrapping 2^D-1 -> 0.
- clr_err=1 clears both flags unless the same cycle sets one; a set wins over clear.
- The RAS is LIFO with a write pointer equal to stack_depth. It is implemented as a register array and read combinationally at index stack_depth-1.

Optional Feature:
Macro PC_HALT_EN.
- Defined: adds input halt_req and output halted (reset 0).
  - A non-stalled halt_req sets halted=1, with priority just below stall.
  - prog_ctr does not advance on that edge.
  - While halted=1, all commands except reset are ignored and the PC and RAS freeze.
  - Only reset clears halted.
- Undefined: neither port exists, and the behaviour is exactly as above.

Decomposition:
- Shared package pc_pkg holds:
  - typedef enum pc_op_t {PC_HOLD, PC_RET, PC_CALL, PC_ABS, PC_REL, PC_INC}, produced by the priority decoder.
  - Default constants PC_D=10, PC_OFFW=8, PC_RAS_S=4.
- One sub-module, pc_ras: parametrised LIFO with push, pop, full, empty and depth outputs. It carries no error logic.
- Priority decode and PC next-value muxing stay in pc_seq.

Test Plan:
All cases use D=10, OFFW=8, S=4.
- Reset and increment: assert reset=0 mid-run with prog_ctr=0x155 -> prog_ctr=0 immediately without a clock; release, 5 edges -> prog_ctr=5.
- Relative branch and wrap: prog_ctr=0x003, offset=8'hF8 (-8) -> 0x3FB; prog_ctr=0x3FE, reljump offset=+4 -> 0x002.
- Nested call/return: calls at PC 0x010, 0x020, 0x030 to targets 0x020, 0x030, 0x040 -> stack_depth=3; three rets -> PC 0x031, 0x021, 0x011, stack_depth=0.
- Overflow and underflow: 5 calls -> ras_ovf=1, stack_depth=4, 5th target still taken; 4 rets return the first four addresses; 5th ret -> ras_unf=1 and PC increments; clr_err -> both flags 0.
- Priority and stall: ret_en+call_en+absjump_en in one cycle with RAS top=0x100 -> PC=0x100; same inputs plus stall=1 -> PC, depth and flags unchanged.
- PC_HALT_EN build: halt_req at PC=0x040 -> halted=1, PC stays 0x040 for 10 cycles despite absjump_en; reset -> halted=0, PC=0.
